srflop_gate_sequencer: RTL and testbench
========================================

# srflop_gate_sequencer

Initiator/reader for the SR-flop gated counter. Accepts a measurement request over a valid/ready handshake and drives the counter's `start` and `stop` pulses a programmed number of cycles apart. It then waits for the counter's delayed `stop_d2` echo, captures the counter's `count`, and returns it over a second valid/ready handshake. A timeout guards against a missing echo.

## Interface
Parameters:
- `CNT_W`, 4, width of the counter value returned by the gated counter.
- `DUR_W`, 8, width of the requested gate duration.
- `TIMEOUT`, 16, number of cycles to wait for `stop_d2` after the stop pulse; must be ≥ 3.

Ports:
- `clk`  in  1  single clock, rising edge.
- `reset`  in  1  asynchronous, active-low reset (0 = reset asserted).
- `req_valid`  in  1  a request is offered.
- `req_ready`  out  1  the block can accept a request; high only in IDLE.
- `req_dur`  in  DUR_W  gate duration D in cycles; 0 is treated as 1.
- `start`  out  1  one-cycle start pulse to the counter.
- `stop`  out  1  one-cycle stop pulse to the counter.
- `count`  in  CNT_W  counter value from the counter.
- `stop_d2`  in  1  stop echo from the counter (stop delayed by 2 cycles).
- `res_valid`  out  1  a result is available.
- `res_count`  out  CNT_W  captured count.
- `res_timeout`  out  1  1 if the echo never arrived.
- `res_ready`  in  1  the consumer accepts the result.

## Operation
- States: IDLE, START, RUN, STOP, WAIT_ECHO, RESULT.
- IDLE:
  - `req_ready`=1.
  - On `req_valid`&`req_ready`, latch Deff = max(`req_dur`,1) and go to START.
- START:
  - `start`=1 for exactly one cycle.
  - Load the run timer with Deff−1.
  - Go to STOP if Deff=1, otherwise go to RUN.
- RUN: decrement the timer each cycle; go to STOP when it reaches 1.
- STOP:
  - `stop`=1 for exactly one cycle.
  - Load the echo timer with TIMEOUT.
  - Go to WAIT_ECHO.
- WAIT_ECHO:
  - On the first cycle with `stop_d2`=1: capture `count` into `res_count`, clear `res_timeout`, go to RESULT.
  - Otherwise decrement the echo timer. When it reaches 0 without an echo: capture `count`, set `res_timeout`=1, go to RESULT.
- RESULT:
  - `res_valid`=1; `res_count` and `res_timeout` are held stable.
  - On `res_ready`=1, go to IDLE.
- `start` and `stop` are never high in the same cycle.
- `stop_d2` is ignored outside WAIT_ECHO, including during the stop-pulse cycle itself.
- The block never pulses `start` again before the current result has been accepted.
- Reset (asynchronous, any state):
  - State returns to IDLE.
  - `start`, `stop`, `res_valid`, and `res_timeout` go to 0; `res_count` goes to 0; timers are cleared.
  - `req_ready` is 1 while in reset and immediately after.
  - A request in flight is dropped silently.

## Timing
- `start`, `stop`, `res_valid`, `res_count`, and `res_timeout` are registered outputs. `req_ready` is decoded from the state register.
- Request accepted at edge E0:
  - `start` is high during cycle E0..E0+1.
  - `stop` is high during cycle E0+Deff..E0+Deff+1.
- Echo window: stop pulse in cycle C; `stop_d2` is sampled in cycles C+1 through C+TIMEOUT.
  - Echo first seen in cycle C+k: `res_valid` rises at the start of cycle C+k+1.
  - No echo: `res_valid` rises with `res_timeout`=1 at cycle C+TIMEOUT+1.
  - A nominal counter echoes at k=2.
- Result handshake:
  - If `res_ready` is already high when `res_valid` rises, `res_valid` lasts exactly one cycle.
  - `req_ready` returns the next cycle.
  - Back-to-back requests are accepted in that IDLE cycle.
- Minimum request-to-request period: Deff + k + 3 cycles.

## Test plan
- **Nominal run.** Reset low for 2 cycles, then `req_dur`=3 against a behavioural gated counter whose `stop_d2` echo arrives 2 cycles after `stop`, with `res_ready`=1.
  - `start` high in cycle 1; `stop` high in cycle 4.
  - Echo in cycle 6.
  - `res_valid` in cycle 7 with `res_count` equal to the counter value at cycle 6 and `res_timeout`=0.
- **Zero duration.** `req_dur`=0.
  - Behaves exactly as `req_dur`=1: `stop` comes one cycle after `start`.
  - Never both high in the same cycle.
- **Missing echo.** Tie `stop_d2`=0 with TIMEOUT=16.
  - `res_valid` with `res_timeout`=1 exactly 17 cycles after the `stop` cycle.
  - `res_count` equals `count` at cycle C+16.
- **Consumer backpressure.** Hold `res_ready`=0 for 5 cycles.
  - `res_valid`, `res_count`, and `res_timeout` are held stable throughout.
  - `req_ready`=0 and a second `req_valid` is not accepted.
  - Release: `req_ready`=1 the next cycle.
- **Reset mid-operation.** Drop `reset` during RUN with `req_dur`=10.
  - Asynchronously `start`=`stop`=`res_valid`=0 and `req_ready`=1.
  - A late echo arriving after reset produces no result.
  - The next request runs normally.
- **Stray echo.** Pulse `stop_d2` during RUN and during the `stop` cycle.
  - Both are ignored; only the in-window echo completes the measurement.

Source files
------------

// File: rtl/srflop_gate_sequencer_if.sv
// Request/result handshake bundle for the SR-flop gated counter sequencer.
// The master issues measurement requests and consumes results.
interface srflop_gate_sequencer_if #(
    parameter int CNT_W = 4,
    parameter int DUR_W = 8
);
    logic             req_valid;
    logic             req_ready;
    logic [DUR_W-1:0] req_dur;
    logic             res_valid;
    logic [CNT_W-1:0] res_count;
    logic             res_timeout;
    logic             res_ready;

    modport master (
        output req_valid, req_dur, res_ready,
        input  req_ready, res_valid, res_count, res_timeout
    );

    modport slave (
        input  req_valid, req_dur, res_ready,
        output req_ready, res_valid, res_count, res_timeout
    );
endinterface

// File: rtl/srflop_gate_sequencer.sv
// Drives start/stop pulses to the gated counter a programmed distance apart,
// waits for the stop_d2 echo (with timeout) and returns the captured count.
module srflop_gate_sequencer #(
    parameter int CNT_W   = 4,
    parameter int DUR_W   = 8,
    parameter int TIMEOUT = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    srflop_gate_sequencer_if.slave   bus,
    output logic                     start,
    output logic                     stop,
    input  logic [CNT_W-1:0]         count,
    input  logic                     stop_d2
);
    localparam int TO_W  = $clog2(TIMEOUT + 1);
    localparam int TMR_W = (DUR_W > TO_W) ? DUR_W : TO_W;

    typedef enum logic [2:0] {
        IDLE, START, RUN, STOP, WAIT_ECHO, RESULT
    } state_e;

    state_e           state_q, state_d;
    logic [DUR_W-1:0] dur_q, dur_d;
    logic [TMR_W-1:0] tmr_q, tmr_d;
    logic             start_q, start_d;
    logic             stop_q, stop_d;
    logic             res_valid_q, res_valid_d;
    logic [CNT_W-1:0] res_count_q, res_count_d;
    logic             res_timeout_q, res_timeout_d;

    always_comb begin
        state_d       = state_q;
        dur_d         = dur_q;
        tmr_d         = tmr_q;
        res_count_d   = res_count_q;
        res_timeout_d = res_timeout_q;
        case (state_q)
            IDLE: begin
                if (bus.req_valid) begin
                    dur_d   = (bus.req_dur == '0) ? DUR_W'(1) : bus.req_dur;
                    state_d = START;
                end
            end
            START: begin
                tmr_d   = TMR_W'(dur_q) - TMR_W'(1);
                state_d = (dur_q == DUR_W'(1)) ? STOP : RUN;
            end
            RUN: begin
                if (tmr_q == TMR_W'(1)) state_d = STOP;
                else                    tmr_d   = tmr_q - TMR_W'(1);
            end
            STOP: begin
                tmr_d   = TMR_W'(TIMEOUT);
                state_d = WAIT_ECHO;
            end
            WAIT_ECHO: begin
                // Last window cycle is when the timer still reads 1.
                if (stop_d2 || tmr_q == TMR_W'(1)) begin
                    res_count_d   = count;
                    res_timeout_d = !stop_d2;
                    tmr_d         = '0;
                    state_d       = RESULT;
                end else begin
                    tmr_d = tmr_q - TMR_W'(1);
                end
            end
            RESULT: begin
                if (bus.res_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        // Pulses are registered versions of the state being entered.
        start_d     = (state_d == START);
        stop_d      = (state_d == STOP);
        res_valid_d = (state_d == RESULT);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= IDLE;
            dur_q         <= '0;
            tmr_q         <= '0;
            start_q       <= 1'b0;
            stop_q        <= 1'b0;
            res_valid_q   <= 1'b0;
            res_count_q   <= '0;
            res_timeout_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            dur_q         <= dur_d;
            tmr_q         <= tmr_d;
            start_q       <= start_d;
            stop_q        <= stop_d;
            res_valid_q   <= res_valid_d;
            res_count_q   <= res_count_d;
            res_timeout_q <= res_timeout_d;
        end
    end

    assign start           = start_q;
    assign stop            = stop_q;
    assign bus.req_ready   = (state_q == IDLE);
    assign bus.res_valid   = res_valid_q;
    assign bus.res_count   = res_count_q;
    assign bus.res_timeout = res_timeout_q;
endmodule

// File: tb/tb_srflop_gate_sequencer.sv
// Bench for srflop_gate_sequencer: behavioural gated counter, scoreboard of
// expected results consumed by an independent result monitor.
module tb_srflop_gate_sequencer;
    localparam int TIMEOUT = 16;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       start, stop, stop_d2;
    logic [3:0] count;

    srflop_gate_sequencer_if #(.CNT_W(4), .DUR_W(8)) bus();

    srflop_gate_sequencer #(.CNT_W(4), .DUR_W(8), .TIMEOUT(TIMEOUT)) dut (
        .clk     (clk),
        .reset   (reset),
        .bus     (bus),
        .start   (start),
        .stop    (stop),
        .count   (count),
        .stop_d2 (stop_d2)
    );

    always #5 clk = ~clk;

    // Gated counter: counts cycles from start through the stop cycle, so the
    // frozen value equals Deff mod 16; stop is echoed two cycles later.
    logic       gate, p1, p2;
    logic [3:0] cnt;
    logic       echo_en = 1'b1;
    logic       stray   = 1'b0;

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            gate <= 1'b0; p1 <= 1'b0; p2 <= 1'b0; cnt <= '0;
        end else begin
            if (start)     begin cnt <= '0; gate <= 1'b1; end
            else if (gate) cnt <= cnt + 4'd1;
            if (stop)      gate <= 1'b0;
            p1 <= stop;
            p2 <= p1;
        end
    end
    assign count   = cnt;
    assign stop_d2 = (p2 & echo_en) | stray;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [3:0] cnt;
        logic       to;
        int         cyc;
    } exp_t;
    exp_t sb[$];

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string nm, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
    endtask

    // Result monitor: checks each new result against the scoreboard and
    // checks that a stalled result stays stable.
    logic       holding = 1'b0;
    logic [3:0] hold_cnt;
    logic       hold_to;
    exp_t       e;

    always @(negedge clk) begin
        if (!reset) begin
            holding = 1'b0;
        end else begin
            if (start && stop) chk("start_stop_overlap", 1, 0);
            if (bus.res_valid) begin
                if (!holding) begin
                    if (sb.size() == 0) begin
                        chk("unexpected_result", 1, 0);
                    end else begin
                        e = sb.pop_front();
                        chk("res_count",   bus.res_count,   e.cnt);
                        chk("res_timeout", bus.res_timeout, e.to);
                        chk("res_cycle",   cyc,             e.cyc);
                    end
                    hold_cnt = bus.res_count;
                    hold_to  = bus.res_timeout;
                    holding  = 1'b1;
                end else begin
                    chk("hold_count",   bus.res_count,   hold_cnt);
                    chk("hold_timeout", bus.res_timeout, hold_to);
                end
                if (bus.res_ready) holding = 1'b0;
            end
        end
    end

    task automatic do_req(input int dur, input bit to, input bit strays, input bit drain);
        int deff;
        int a;
        deff = (dur == 0) ? 1 : dur;
        @(negedge clk);
        for (int i = 0; i < 50 && !bus.req_ready; i++) @(negedge clk);
        chk("req_ready_idle", bus.req_ready, 1);
        a = cyc + 1;
        sb.push_back('{cnt: 4'(deff), to: to, cyc: a + deff + (to ? TIMEOUT + 1 : 3)});
        bus.req_valid = 1'b1;
        bus.req_dur   = 8'(dur);
        @(negedge clk);
        bus.req_valid = 1'b0;
        for (int c = a; c <= a + deff; c++) begin
            chk("start_pulse", start, int'(c == a));
            chk("stop_pulse",  stop,  int'(c == a + deff));
            if (strays) stray = (c == a + 1) || (c == a + deff);
            @(negedge clk);
        end
        stray = 1'b0;
        chk("stop_one_cycle", stop, 0);
        if (drain) begin
            for (int i = 0; i < 100 && (sb.size() != 0 || bus.res_valid); i++) @(negedge clk);
            chk("drained", sb.size(), 0);
        end
    endtask

    initial begin
        int seen;
        bus.req_valid = 1'b0;
        bus.req_dur   = '0;
        bus.res_ready = 1'b1;

        // Reset state
        @(negedge clk);
        chk("rst_req_ready", bus.req_ready, 1);
        chk("rst_start",     start, 0);
        chk("rst_stop",      stop, 0);
        chk("rst_res_valid", bus.res_valid, 0);
        chk("rst_res_to",    bus.res_timeout, 0);
        chk("rst_res_count", bus.res_count, 0);
        @(negedge clk);
        reset = 1'b1;

        do_req(3, 0, 0, 1);   // nominal
        do_req(0, 0, 0, 1);   // zero duration behaves as 1
        do_req(1, 0, 0, 1);
        do_req(20, 0, 0, 1);  // count wraps to 4

        // Missing echo
        echo_en = 1'b0;
        do_req(2, 1, 0, 1);
        echo_en = 1'b1;

        // Consumer backpressure
        bus.res_ready = 1'b0;
        do_req(5, 0, 0, 0);
        for (int i = 0; i < 20 && !bus.res_valid; i++) @(negedge clk);
        chk("bp_res_valid", bus.res_valid, 1);
        for (int i = 0; i < 5; i++) begin
            chk("bp_req_ready", bus.req_ready, 0);
            chk("bp_no_start",  start, 0);
            bus.req_valid = 1'b1;
            bus.req_dur   = 8'd2;
            @(negedge clk);
        end
        bus.req_valid = 1'b0;
        bus.res_ready = 1'b1;
        @(negedge clk);
        chk("bp_release_ready", bus.req_ready, 1);
        chk("bp_release_valid", bus.res_valid, 0);
        chk("bp_sb_empty",      sb.size(), 0);

        // Reset in the middle of RUN
        bus.req_valid = 1'b1;
        bus.req_dur   = 8'd10;
        @(negedge clk);
        bus.req_valid = 1'b0;
        repeat (3) @(negedge clk);
        #2 reset = 1'b0;
        #1;
        chk("mid_rst_start",     start, 0);
        chk("mid_rst_stop",      stop, 0);
        chk("mid_rst_res_valid", bus.res_valid, 0);
        chk("mid_rst_req_ready", bus.req_ready, 1);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        stray = 1'b1;
        @(negedge clk);
        stray = 1'b0;
        seen = 0;
        for (int i = 0; i < 20; i++) begin
            if (bus.res_valid) seen++;
            @(negedge clk);
        end
        chk("no_result_after_reset", seen, 0);
        do_req(4, 0, 0, 1);

        // Stray echoes in RUN and in the stop cycle
        do_req(10, 0, 1, 1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d passed", n_pass, n_chk);
        $fatal(1);
    end
endmodule
